clip_event_monitor: RTL and testbench

//  Digital front end beside the CLIP-SAFE analog core. Consumes the three comparator outputs (core drives io_in[29:27]).
//  Per channel: synchronise, deglitch, count clip events.

---
 rtl/clip_safe_pkg.sv | 41 ++++
 rtl/cmp_deglitch.sv | 67 ++++++
 rtl/clip_event_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_clip_event_monitor.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clip_safe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : clip_safe_pkg
// Description : Shared constants, state encoding and helpers for the
//               CLIP-SAFE digital event monitor.
// Contents    : NUM_CMP comparator count, io_out bit positions, FSM state
//               enum, comparator popcount helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clip_safe_pkg;

    // Number of comparator channels coming from the analog core
    localparam int unsigned NUM_CMP    = 3;

    // GPIO status byte layout
    localparam int unsigned IO_W       = 8;
    localparam int unsigned IO_ALARM   = 7;
    localparam int unsigned IO_LVL_LSB = 4;
    localparam int unsigned IO_CNT_LSB = 0;
    localparam int unsigned IO_CNT_W   = 4;

    // Monitor state machine
    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_ALARM    = 2'd2,
        ST_HOLD     = 2'd3
    } state_e;

    // Number of channels that produced an event in the same cycle
    function automatic logic [IO_CNT_W-1:0] popcount(input logic [NUM_CMP-1:0] v);
        logic [IO_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CMP; i++) begin
            n = n + IO_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_deglitch.sv
`default_nettype none
// ============================================================================
// Module      : cmp_deglitch
// Description : Conditions one raw comparator level: 2-FF synchroniser,
//               run-length debounce and 0->1 event pulse.
// Ports       : clk_i    - block clock
//               rst_n_i  - asynchronous active-low reset
//               raw_i    - raw comparator level (asynchronous)
//               level_o  - filtered level (registered)
//               rise_o   - high in the cycle whose edge raises level_o
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_deglitch #(
    parameter int unsigned DEB_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned RUN_W = $clog2(DEB_LEN);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             level_d;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            run_q   <= '0;
        end else begin
            meta_q  <= raw_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            run_q   <= run_d;
        end
    end

    // run_q counts consecutive synchronised samples that disagree with the
    // current filtered level; any agreeing sample restarts the count, and
    // the DEB_LEN-th disagreeing sample flips the level.
    always_comb begin
        level_d = level_q;
        run_d   = '0;
        if (sync_q != level_q) begin
            if (run_q == RUN_W'(DEB_LEN - 1)) begin
                level_d = sync_q;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    assign level_o = level_q;
    // Event is flagged in the cycle before level_o rises, so downstream
    // counters update on the same edge as the filtered level.
    assign rise_o  = level_d & ~level_q;

endmodule
`default_nettype wire

// File: rtl/clip_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clip_event_monitor
// Description : Digital front end for the CLIP-SAFE analog core. Deglitches
//               three comparator outputs, counts clip events per channel and
//               raises a latched alarm when too many events land inside one
//               time window. Status is packed onto eight GPIO outputs.
// Ports       : wb_clk_i   - clock
//               wb_rst_n_i - asynchronous active-low reset
//               cmp_i      - raw comparator levels (asynchronous)
//               en_i       - monitor enable
//               clr_i      - clear counters / acknowledge alarm (pulse)
//               alarm_o    - latched clip alarm
//               cnt_o      - per-channel saturating event counts, ch0 in LSBs
//               io_out_o   - {alarm, filtered levels[2:0], window events[3:0]}
//               io_oeb_o   - GPIO output enables, active low
// Revision    : 1.0 - initial release
// ============================================================================
module clip_event_monitor
    import clip_safe_pkg::*;
#(
    parameter int unsigned DEB_LEN    = 4,
    parameter int unsigned WIN_CYC    = 1024,
    parameter int unsigned EVT_THRESH = 3,
    parameter int unsigned HOLD_CYC   = 256,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic [NUM_CMP-1:0]       cmp_i,
    input  logic                     en_i,
    input  logic                     clr_i,
    output logic                     alarm_o,
    output logic [NUM_CMP*CNT_W-1:0] cnt_o,
    output logic [IO_W-1:0]          io_out_o,
    output logic [IO_W-1:0]          io_oeb_o
);

    localparam int unsigned         WIN_W   = $clog2(WIN_CYC);
    localparam int unsigned         HOLD_W  = $clog2(HOLD_CYC);
    localparam logic [CNT_W-1:0]    CNT_MAX = '1;
    localparam logic [IO_CNT_W-1:0] EVT_MAX = '1;
    localparam logic [IO_CNT_W:0]   THRESH  = (IO_CNT_W + 1)'(EVT_THRESH);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [NUM_CMP-1:0] w_level;
    logic [NUM_CMP-1:0] w_rise;

    generate
        for (genvar g = 0; g < NUM_CMP; g++) begin : g_cmp
            cmp_deglitch #(
                .DEB_LEN (DEB_LEN)
            ) u_deglitch (
                .clk_i   (wb_clk_i),
                .rst_n_i (wb_rst_n_i),
                .raw_i   (cmp_i[g]),
                .level_o (w_level[g]),
                .rise_o  (w_rise[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    state_e                           state_q,    state_d;
    logic [WIN_W-1:0]                 win_cnt_q,  win_cnt_d;
    logic [IO_CNT_W-1:0]              win_evt_q,  win_evt_d;
    logic [HOLD_W-1:0]                hold_cnt_q, hold_cnt_d;
    logic [NUM_CMP-1:0][CNT_W-1:0]    cnt_q,      cnt_d;
    logic                             alarm_q;
    logic [IO_W-1:0]                  io_out_q;
    logic [IO_W-1:0]                  io_oeb_q;

    logic [IO_CNT_W-1:0] w_pop;
    logic [IO_CNT_W-1:0] w_base;
    logic [IO_CNT_W:0]   w_sum;
    logic                w_wrap;
    logic                w_count_en;
    logic [IO_W-1:0]     w_io_out_d;

    assign w_pop      = popcount(w_rise);
    assign w_wrap     = (win_cnt_q == WIN_W'(WIN_CYC - 1));
    // On the wrap cycle the window restarts, so that cycle's events are
    // accumulated on top of zero rather than the expiring total.
    assign w_base     = w_wrap ? '0 : win_evt_q;
    assign w_sum      = {1'b0, w_base} + {1'b0, w_pop};
    assign w_count_en = (state_q == ST_ARMED) || (state_q == ST_ALARM);

    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        win_evt_d  = win_evt_q;
        hold_cnt_d = hold_cnt_q;

        if (!en_i) begin
            state_d    = ST_DISABLED;
            win_cnt_d  = '0;
            win_evt_d  = '0;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d   = ST_ARMED;
                    win_cnt_d = '0;
                    win_evt_d = '0;
                end

                ST_ARMED: begin
                    win_cnt_d = w_wrap ? '0 : win_cnt_q + WIN_W'(1);
                    if (clr_i) begin
                        // Clear wins over any event landing in this cycle
                        win_evt_d = '0;
                    end else begin
                        win_evt_d = (w_sum > {1'b0, EVT_MAX}) ? EVT_MAX
                                                               : w_sum[IO_CNT_W-1:0];
                        if (w_sum >= THRESH) begin
                            state_d = ST_ALARM;
                        end
                    end
                end

                ST_ALARM: begin
                    // Acknowledge only once the clipping condition has gone
                    if (clr_i) begin
                        win_evt_d = '0;
                        if (w_level == '0) begin
                            state_d    = ST_HOLD;
                            hold_cnt_d = '0;
                        end
                    end
                end

                ST_HOLD: begin
                    if (clr_i) begin
                        win_evt_d = '0;
                    end
                    if (hold_cnt_q == HOLD_W'(HOLD_CYC - 1)) begin
                        state_d    = ST_ARMED;
                        win_cnt_d  = '0;
                        win_evt_d  = '0;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end

                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end
    end

    // Per-channel saturating counters; clear has priority over an event
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_CMP; i++) begin
            if (clr_i) begin
                cnt_d[i] = '0;
            end else if (w_count_en && w_rise[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // GPIO status byte, built from the current registered state and
    // registered once more before leaving the block
    always_comb begin
        w_io_out_d                            = '0;
        w_io_out_d[IO_ALARM]                  = alarm_q;
        w_io_out_d[IO_LVL_LSB +: NUM_CMP]     = w_level;
        w_io_out_d[IO_CNT_LSB +: IO_CNT_W]    = win_evt_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_DISABLED;
            win_cnt_q  <= '0;
            win_evt_q  <= '0;
            hold_cnt_q <= '0;
            cnt_q      <= '0;
            alarm_q    <= 1'b0;
            io_out_q   <= '0;
            io_oeb_q   <= '1;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            win_evt_q  <= win_evt_d;
            hold_cnt_q <= hold_cnt_d;
            cnt_q      <= cnt_d;
            alarm_q    <= (state_d == ST_ALARM);
            io_out_q   <= w_io_out_d;
            io_oeb_q   <= '0;
        end
    end

    assign alarm_o  = alarm_q;
    assign cnt_o    = cnt_q;
    assign io_out_o = io_out_q;
    assign io_oeb_o = io_oeb_q;

endmodule
`default_nettype wire

// File: tb/tb_clip_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_clip_event_monitor
// Description : Self-checking bench for clip_event_monitor: table of pulse
//               vectors, directed corner sequences and a randomized run
//               compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clip_event_monitor;

    localparam int DEB_LEN    = 4;
    localparam int WIN_CYC    = 1024;
    localparam int EVT_THRESH = 3;
    localparam int HOLD_CYC   = 256;
    localparam int CNT_W      = 8;

    localparam int S_DIS   = 0;
    localparam int S_ARM   = 1;
    localparam int S_ALARM = 2;
    localparam int S_HOLD  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  cmp;
    logic        en;
    logic        clr;
    logic        alarm;
    logic [23:0] cnt;
    logic [7:0]  io_out;
    logic [7:0]  io_oeb;

    always #5 clk = ~clk;

    clip_event_monitor #(
        .DEB_LEN    (DEB_LEN),
        .WIN_CYC    (WIN_CYC),
        .EVT_THRESH (EVT_THRESH),
        .HOLD_CYC   (HOLD_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .cmp_i      (cmp),
        .en_i       (en),
        .clr_i      (clr),
        .alarm_o    (alarm),
        .cnt_o      (cnt),
        .io_out_o   (io_out),
        .io_oeb_o   (io_oeb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model (cycle-level, history based)
    // ------------------------------------------------------------------
    bit          model_on = 1'b0;
    logic [2:0]  m_raw_q[$];   // raw values seen at the last two edges
    logic [2:0]  m_samp_q[$];  // last DEB_LEN synchronised samples
    logic [2:0]  m_lvl;
    int          m_cnt[3];
    int          m_state;
    int          m_pos;
    int          m_evt;
    int          m_hold;
    logic        m_alarm;
    logic [7:0]  m_io_out;
    logic [7:0]  m_io_oeb;

    task automatic model_reset();
        m_raw_q.delete();
        m_raw_q.push_back(3'b000);
        m_raw_q.push_back(3'b000);
        m_samp_q.delete();
        for (int i = 0; i < DEB_LEN; i++) m_samp_q.push_back(3'b000);
        m_lvl    = 3'b000;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_state  = S_DIS;
        m_pos    = 0;
        m_evt    = 0;
        m_hold   = 0;
        m_alarm  = 1'b0;
        m_io_out = 8'h00;
        m_io_oeb = 8'hFF;
    endtask

    task automatic model_step();
        logic [2:0] samp;
        logic [2:0] new_lvl;
        logic [2:0] rise;
        int         pop;
        int         base;
        int         total;
        bit         all_opp;

        samp = m_raw_q[0];
        void'(m_raw_q.pop_front());
        m_raw_q.push_back(cmp);
        m_samp_q.push_back(samp);
        void'(m_samp_q.pop_front());

        // A level flips once the whole recent history disagrees with it
        new_lvl = m_lvl;
        for (int ch = 0; ch < 3; ch++) begin
            all_opp = 1'b1;
            foreach (m_samp_q[k]) if (m_samp_q[k][ch] == m_lvl[ch]) all_opp = 1'b0;
            if (all_opp) new_lvl[ch] = ~m_lvl[ch];
        end
        rise = new_lvl & ~m_lvl;
        pop  = $countones(rise);

        m_io_out = {m_alarm, m_lvl, 4'(m_evt)};
        m_io_oeb = 8'h00;

        if (clr) begin
            for (int ch = 0; ch < 3; ch++) m_cnt[ch] = 0;
        end else if (m_state == S_ARM || m_state == S_ALARM) begin
            for (int ch = 0; ch < 3; ch++)
                if (rise[ch] && m_cnt[ch] < (1 << CNT_W) - 1) m_cnt[ch]++;
        end

        if (!en) begin
            m_state = S_DIS; m_pos = 0; m_evt = 0; m_hold = 0;
        end else if (m_state == S_DIS) begin
            m_state = S_ARM; m_pos = 0; m_evt = 0;
        end else if (m_state == S_ARM) begin
            if (m_pos == WIN_CYC - 1) begin base = 0; m_pos = 0; end
            else begin base = m_evt; m_pos++; end
            if (clr) m_evt = 0;
            else begin
                total = base + pop;
                m_evt = (total > 15) ? 15 : total;
                if (total >= EVT_THRESH) m_state = S_ALARM;
            end
        end else if (m_state == S_ALARM) begin
            if (clr) begin
                m_evt = 0;
                if (m_lvl == 3'b000) begin m_state = S_HOLD; m_hold = 0; end
            end
        end else begin
            if (clr) m_evt = 0;
            if (m_hold == HOLD_CYC - 1) begin m_state = S_ARM; m_pos = 0; m_evt = 0; m_hold = 0; end
            else m_hold++;
        end

        m_alarm = (m_state == S_ALARM);
        m_lvl   = new_lvl;
    endtask

    task automatic model_compare();
        check("rand alarm",  {31'b0, alarm}, {31'b0, m_alarm});
        check("rand cnt",    {8'b0, cnt}, {8'b0, 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
        check("rand io_out", {24'b0, io_out}, {24'b0, m_io_out});
        check("rand io_oeb", {24'b0, io_oeb}, {24'b0, m_io_oeb});
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        if (model_on) model_step();
        @(posedge clk);
        #1;
        if (model_on) model_compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmp   = 3'b000;
        en    = 1'b0;
        clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse(input int ch, input int len);
        cmp[ch] = 1'b1;
        repeat (len) tick();
        cmp[ch] = 1'b0;
    endtask

    typedef struct {
        int          ch;
        int          len;
        logic [23:0] exp_cnt;
        logic        exp_alarm;
        logic [3:0]  exp_evt;
    } vec_t;

    vec_t        vecs[6];
    int          run[3];
    logic [2:0]  r_lvl;
    bit          long_ph;
    bit          quiet;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset behaviour ----------------
        rst_n = 1'b0; cmp = 3'b000; en = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset io_oeb", {24'b0, io_oeb}, 32'hFF);
        check("reset io_out", {24'b0, io_out}, 32'h00);
        check("reset alarm",  {31'b0, alarm}, 32'h0);
        check("reset cnt",    {8'b0, cnt}, 32'h0);
        rst_n = 1'b1;
        check("release io_oeb pre-edge", {24'b0, io_oeb}, 32'hFF);
        tick();
        check("release io_oeb", {24'b0, io_oeb}, 32'h00);
        check("release alarm",  {31'b0, alarm}, 32'h0);

        // ---------------- pulse-length table ----------------
        vecs[0] = '{0, 3, 24'h000000, 1'b0, 4'd0};
        vecs[1] = '{0, 6, 24'h000001, 1'b0, 4'd1};
        vecs[2] = '{2, 2, 24'h000001, 1'b0, 4'd1};
        vecs[3] = '{2, 3, 24'h000001, 1'b0, 4'd1};
        vecs[4] = '{1, 4, 24'h000101, 1'b0, 4'd2};
        vecs[5] = '{2, 5, 24'h010101, 1'b1, 4'd3};
        en = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 6; i++) begin
            pulse(vecs[i].ch, vecs[i].len);
            repeat (12) tick();
            check($sformatf("table%0d cnt", i),   {8'b0, cnt}, {8'b0, vecs[i].exp_cnt});
            check($sformatf("table%0d alarm", i), {31'b0, alarm}, {31'b0, vecs[i].exp_alarm});
            check($sformatf("table%0d evt", i),   {28'b0, io_out[3:0]}, {28'b0, vecs[i].exp_evt});
        end

        // ---------------- filter latency ----------------
        do_reset();
        en = 1'b1;
        repeat (2) tick();
        cmp[0] = 1'b1;
        repeat (5) tick();
        check("latency before 6th edge", {8'b0, cnt}, 32'h0);
        tick();
        check("latency at 6th edge", {8'b0, cnt}, 32'h1);
        tick();
        check("latency io_out level", {31'b0, io_out[4]}, 32'h1);
        cmp[0] = 1'b0;

        // ---------------- alarm with simultaneous rises ----------------
        do_reset();
        en = 1'b1;
        repeat (10) tick();
        cmp[1] = 1'b1;
        repeat (20) tick();
        check("alarm pre cnt",   {8'b0, cnt}, 32'h000100);
        check("alarm pre alarm", {31'b0, alarm}, 32'h0);
        cmp[0] = 1'b1;
        cmp[2] = 1'b1;
        repeat (5) tick();
        check("alarm before flip", {31'b0, alarm}, 32'h0);
        tick();
        check("alarm raised", {31'b0, alarm}, 32'h1);
        check("alarm cnt",    {8'b0, cnt}, 32'h010101);
        tick();
        check("alarm io_out", {24'b0, io_out}, 32'hF3);

        // ---------------- clear rules ----------------
        cmp[0] = 1'b0;
        cmp[2] = 1'b0;
        repeat (12) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr with level high keeps alarm", {31'b0, alarm}, 32'h1);
        cmp[1] = 1'b0;
        repeat (12) tick();
        check("alarm still latched", {31'b0, alarm}, 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr ack alarm", {31'b0, alarm}, 32'h0);
        check("clr ack cnt",   {8'b0, cnt}, 32'h0);
        pulse(0, 6);
        repeat (12) tick();
        check("hold ignores events cnt", {8'b0, cnt}, 32'h0);
        check("hold ignores events evt", {28'b0, io_out[3:0]}, 32'h0);
        repeat (260) tick();
        pulse(1, 6);
        repeat (12) tick();
        check("after hold cnt",   {8'b0, cnt}, 32'h000100);
        check("after hold alarm", {31'b0, alarm}, 32'h0);
        check("after hold evt",   {28'b0, io_out[3:0]}, 32'h1);

        // ---------------- window expiry ----------------
        do_reset();
        en = 1'b1;
        repeat (2) tick();
        pulse(0, 6);
        repeat (12) tick();
        pulse(1, 6);
        repeat (12) tick();
        check("window two events", {28'b0, io_out[3:0]}, 32'h2);
        repeat (1100) tick();
        check("window expired", {28'b0, io_out[3:0]}, 32'h0);
        pulse(2, 6);
        repeat (12) tick();
        check("window no alarm", {31'b0, alarm}, 32'h0);
        check("window evt",      {28'b0, io_out[3:0]}, 32'h1);
        check("window cnt",      {8'b0, cnt}, 32'h010101);

        // ---------------- saturation ----------------
        do_reset();
        en = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 300; i++) begin
            pulse(2, 5);
            repeat (5) tick();
        end
        repeat (12) tick();
        check("saturate cnt",   {8'b0, cnt}, 32'hFF0000);
        check("saturate alarm", {31'b0, alarm}, 32'h1);

        // ---------------- clear beats simultaneous event ----------------
        cmp[0] = 1'b1;
        repeat (5) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr beats event", {8'b0, cnt}, 32'h0);
        cmp[0] = 1'b0;
        repeat (12) tick();

        // ---------------- en dropped during alarm ----------------
        do_reset();
        en = 1'b1;
        repeat (2) tick();
        for (int ch = 0; ch < 3; ch++) begin
            pulse(ch, 6);
            repeat (12) tick();
        end
        check("en-drop pre alarm", {31'b0, alarm}, 32'h1);
        en = 1'b0;
        tick();
        check("en-drop alarm",  {31'b0, alarm}, 32'h0);
        check("en-drop cnt",    {8'b0, cnt}, 32'h010101);
        tick();
        check("en-drop io_out", {24'b0, io_out}, 32'h00);

        // ---------------- async reset mid-window ----------------
        en = 1'b1;
        repeat (2) tick();
        pulse(0, 6);
        repeat (12) tick();
        check("mid-window cnt", {8'b0, cnt}, 32'h010102);
        rst_n = 1'b0;
        #1;
        check("async reset alarm",  {31'b0, alarm}, 32'h0);
        check("async reset cnt",    {8'b0, cnt}, 32'h0);
        check("async reset io_out", {24'b0, io_out}, 32'h00);
        check("async reset io_oeb", {24'b0, io_oeb}, 32'hFF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---------------- randomized run against the model ----------------
        do_reset();
        model_reset();
        model_on = 1'b1;
        r_lvl = 3'b000;
        for (int ch = 0; ch < 3; ch++) run[ch] = 0;
        for (int c = 0; c < 20000 && n_fail < 50; c++) begin
            long_ph = ((c / 3000) % 2) == 1;
            quiet   = (c % 700) >= 640;
            for (int ch = 0; ch < 3; ch++) begin
                if (run[ch] == 0) begin
                    r_lvl[ch] = ~r_lvl[ch];
                    run[ch]   = long_ph ? int'($urandom_range(20, 600)) : int'($urandom_range(1, 12));
                end else begin
                    run[ch]--;
                end
            end
            cmp = quiet ? 3'b000 : r_lvl;
            clr = ((c % 700) == 690) || ($urandom_range(0, 299) == 0);
            en  = !(((c % 2500) >= 2400) && ((c % 2500) < 2408));
            tick();
        end
        model_on = 1'b0;
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
